// File: rtl/forward_hazard_unit.sv
`default_nettype none
// ============================================================================
// forward_hazard_unit: NSRC-operand EX forwarding select, load-use and
// multi-cycle (mul/div) hazard detection. Optional macro: FWD_HAZARD_STATS_EN.
// Revision: 1.0
// ============================================================================
module forward_hazard_unit #(
  parameter int AW     = 5,
  parameter int NSRC   = 2,
  parameter int MC_LAT = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NSRC*AW-1:0]   ie_src_i,
  input  logic                 em_regwrite_i,
  input  logic [AW-1:0]        em_rd_i,
  input  logic                 mw_regwrite_i,
  input  logic [AW-1:0]        mw_rd_i,
  output logic [2*NSRC-1:0]    fwd_o,
  input  logic [NSRC*AW-1:0]   id_src_i,
  input  logic [NSRC-1:0]      id_src_vld_i,
  input  logic                 id_mc_i,
  input  logic                 ie_memread_i,
  input  logic [AW-1:0]        ie_rd_i,
  input  logic                 mc_start_i,
  input  logic [AW-1:0]        mc_rd_i,
  output logic                 mc_busy_o,
  output logic                 mc_done_o,
  output logic                 stall_o,
`ifdef FWD_HAZARD_STATS_EN
  output logic                 bubble_o,
  output logic [31:0]          stall_cnt_o
`else
  output logic                 bubble_o
`endif
);

  localparam logic       c_IDLE = 1'b0;
  localparam logic       c_BUSY = 1'b1;
  localparam logic [3:0] c_LAT  = 4'(MC_LAT);

  logic          state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] mc_rd_q, mc_rd_d;

  logic [NSRC-1:0] w_lu_hit;
  logic [NSRC-1:0] w_mcq_hit;
  logic [NSRC-1:0] w_mcs_hit;
  logic            w_busy;
  logic            w_load_use;
  logic            w_raw_mc;
  logic            w_struct;
  logic            w_hazard;

  assign w_busy = (state_q == c_BUSY);

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    logic [AW-1:0] w_ex_src;
    logic [AW-1:0] w_id_src;
    logic          w_em_hit;
    logic          w_mw_hit;

    assign w_ex_src = ie_src_i[k*AW +: AW];
    assign w_id_src = id_src_i[k*AW +: AW];
    assign w_em_hit = em_regwrite_i && (em_rd_i != '0) && (em_rd_i == w_ex_src);
    assign w_mw_hit = mw_regwrite_i && (mw_rd_i != '0) && (mw_rd_i == w_ex_src);

    // Nonzero checks on the producer side are applied once, outside the loop.
    assign w_lu_hit[k]  = id_src_vld_i[k] && (ie_rd_i == w_id_src);
    assign w_mcq_hit[k] = id_src_vld_i[k] && (mc_rd_q == w_id_src);
    assign w_mcs_hit[k] = id_src_vld_i[k] && (mc_rd_i == w_id_src);

    assign fwd_o[2*k +: 2] = !rst_i   ? 2'b00 :
                             w_em_hit ? 2'b10 :
                             w_mw_hit ? 2'b01 : 2'b00;
  end

  assign w_load_use = ie_memread_i && (ie_rd_i != '0) && (|w_lu_hit);
  assign w_raw_mc   = (w_busy && (mc_rd_q != '0) && (|w_mcq_hit)) ||
                      (mc_start_i && (mc_rd_i != '0) && (|w_mcs_hit));
  assign w_struct   = id_mc_i && (w_busy || mc_start_i);
  assign w_hazard   = w_load_use || w_raw_mc || w_struct;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= c_IDLE;
      cnt_q   <= '0;
      mc_rd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mc_rd_q <= mc_rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mc_rd_d = mc_rd_q;
    case (state_q)
      c_IDLE: begin
        if (mc_start_i) begin
          state_d = c_BUSY;
          cnt_d   = c_LAT;
          mc_rd_d = mc_rd_i;
        end
      end
      c_BUSY: begin
        // A start request while busy is dropped; the structural stall prevents it.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = c_IDLE;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    mc_busy_o = w_busy;
    mc_done_o = w_busy && (cnt_q == 4'd1);
    stall_o   = rst_i && w_hazard;
    bubble_o  = rst_i && w_hazard;
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_forward_hazard_unit.sv
`default_nettype none
// ============================================================================
// tb_forward_hazard_unit: directed scenarios plus randomized traffic checked
// against a cycle-indexed behavioural model of forward_hazard_unit.
// Revision: 1.0
// ============================================================================
module tb_forward_hazard_unit;
  localparam int AW     = 5;
  localparam int NSRC   = 2;
  localparam int MC_LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [NSRC*AW-1:0]  ie_src, id_src;
  logic                em_regwrite, mw_regwrite, id_mc, ie_memread, mc_start;
  logic [AW-1:0]       em_rd, mw_rd, ie_rd, mc_rd;
  logic [NSRC-1:0]     id_vld;
  logic [2*NSRC-1:0]   fwd;
  logic                busy, done, stall, bubble;
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0]         stall_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  // Model: the op accepted at cycle m_start is busy in cycles m_start+1..m_start+MC_LAT.
  int            cyc     = 0;
  int            m_start = -1000;
  logic [AW-1:0] m_rd    = '0;
  logic [31:0]   m_scnt  = '0;

  forward_hazard_unit #(.AW(AW), .NSRC(NSRC), .MC_LAT(MC_LAT)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .ie_src_i     (ie_src),
    .em_regwrite_i(em_regwrite),
    .em_rd_i      (em_rd),
    .mw_regwrite_i(mw_regwrite),
    .mw_rd_i      (mw_rd),
    .fwd_o        (fwd),
    .id_src_i     (id_src),
    .id_src_vld_i (id_vld),
    .id_mc_i      (id_mc),
    .ie_memread_i (ie_memread),
    .ie_rd_i      (ie_rd),
    .mc_start_i   (mc_start),
    .mc_rd_i      (mc_rd),
    .mc_busy_o    (busy),
    .mc_done_o    (done),
    .stall_o      (stall),
`ifdef FWD_HAZARD_STATS_EN
    .bubble_o     (bubble),
    .stall_cnt_o  (stall_cnt)
`else
    .bubble_o     (bubble)
`endif
  );

  function automatic logic [AW-1:0] sel(logic [NSRC*AW-1:0] bus, int k);
    return bus[k*AW +: AW];
  endfunction

  function automatic bit m_busy();
    return (cyc > m_start) && (cyc <= m_start + MC_LAT);
  endfunction

  function automatic bit m_done();
    return cyc == m_start + MC_LAT;
  endfunction

  function automatic logic [2*NSRC-1:0] m_fwd();
    logic [2*NSRC-1:0] r = '0;
    if (!rst_n) return r;
    for (int k = 0; k < NSRC; k++) begin
      if (em_regwrite && em_rd != 0 && em_rd == sel(ie_src, k)) r[2*k +: 2] = 2'b10;
      else if (mw_regwrite && mw_rd != 0 && mw_rd == sel(ie_src, k)) r[2*k +: 2] = 2'b01;
    end
    return r;
  endfunction

  function automatic bit reads(logic [AW-1:0] rd);
    if (rd == 0) return 1'b0;
    for (int k = 0; k < NSRC; k++)
      if (id_vld[k] && sel(id_src, k) == rd) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_stall();
    if (!rst_n) return 1'b0;
    return (ie_memread && reads(ie_rd)) || (m_busy() && reads(m_rd)) ||
           (mc_start && reads(mc_rd)) || (id_mc && (m_busy() || mc_start));
  endfunction

  task automatic tick();
    bit s;
    s = m_stall();
    if (!rst_n) begin
      m_start = -1000;
      m_scnt  = '0;
    end else begin
      if (s && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 32'd1;
      if (mc_start && !m_busy()) begin
        m_start = cyc;
        m_rd    = mc_rd;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs();
    ie_src = '0; id_src = '0; id_vld = '0;
    em_regwrite = 1'b0; mw_regwrite = 1'b0; id_mc = 1'b0;
    ie_memread = 1'b0; mc_start = 1'b0;
    em_rd = '0; mw_rd = '0; ie_rd = '0; mc_rd = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    ie_src = {5'd4, 5'd3}; em_regwrite = 1'b1; em_rd = 5'd3;
    ie_memread = 1'b1; ie_rd = 5'd3; id_src = {5'd0, 5'd3}; id_vld = 2'b01;
    mc_start = 1'b1; mc_rd = 5'd3;
    tick(); tick();
    @(negedge clk);
    vectors++;
    if (fwd !== 4'b0000) begin errors++; $display("FAIL reset_fwd got=%b exp=0000", fwd); end
    vectors++;
    if ({stall, bubble} !== 2'b00) begin errors++; $display("FAIL reset_stall got=%b exp=00", {stall, bubble}); end
    vectors++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_mc got=%b exp=00", {busy, done}); end
    clear_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    ie_src = {5'd4, 5'd3}; em_regwrite = 1'b1; em_rd = 5'd3; mw_regwrite = 1'b1; mw_rd = 5'd3;
    #1;
    vectors++;
    if (fwd !== 4'b0010) begin errors++; $display("FAIL fwd_em_priority got=%b exp=0010", fwd); end
    em_rd = 5'd0;
    #1;
    vectors++;
    if (fwd !== 4'b0001) begin errors++; $display("FAIL fwd_em_rd0 got=%b exp=0001", fwd); end
    mw_rd = 5'd0;
    #1;
    vectors++;
    if (fwd !== 4'b0000) begin errors++; $display("FAIL fwd_both_rd0 got=%b exp=0000", fwd); end
    em_rd = 5'd4; mw_rd = 5'd3; em_regwrite = 1'b1; mw_regwrite = 1'b1;
    #1;
    vectors++;
    if (fwd !== 4'b1001) begin errors++; $display("FAIL fwd_mixed got=%b exp=1001", fwd); end
    em_regwrite = 1'b0; mw_regwrite = 1'b0;
    #1;
    vectors++;
    if (fwd !== 4'b0000) begin errors++; $display("FAIL fwd_no_write got=%b exp=0000", fwd); end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    ie_memread = 1'b1; ie_rd = 5'd7; id_src = {5'd2, 5'd7}; id_vld = 2'b11;
    @(negedge clk);
    vectors++;
    if ({stall, bubble} !== 2'b11) begin errors++; $display("FAIL load_use got=%b exp=11", {stall, bubble}); end
    tick();
    ie_memread = 1'b0; em_regwrite = 1'b1; em_rd = 5'd7;
    @(negedge clk);
    vectors++;
    if ({stall, bubble} !== 2'b00) begin errors++; $display("FAIL load_use_one_cycle got=%b exp=00", {stall, bubble}); end
    tick();
    clear_inputs();
    ie_memread = 1'b1; ie_rd = 5'd7; id_src = {5'd2, 5'd7}; id_vld = 2'b10;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0) begin errors++; $display("FAIL load_use_invalid_src got=%b exp=0", stall); end
    ie_rd = 5'd0; id_src = {5'd2, 5'd0}; id_vld = 2'b11;
    #1;
    vectors++;
    if (stall !== 1'b0) begin errors++; $display("FAIL load_use_rd0 got=%b exp=0", stall); end
    tick();
  endtask

  task automatic test_multicycle();
    clear_inputs();
    mc_start = 1'b1; mc_rd = 5'd9; id_src = {5'd0, 5'd9}; id_vld = 2'b01;
    for (int c = 0; c <= MC_LAT + 1; c++) begin
      logic eb, ed, es;
      eb = (c >= 1) && (c <= MC_LAT);
      ed = (c == MC_LAT);
      es = (c <= MC_LAT);
      @(negedge clk);
      vectors++;
      if (busy !== eb) begin errors++; $display("FAIL mc_busy cyc%0d got=%b exp=%b", c, busy, eb); end
      vectors++;
      if (done !== ed) begin errors++; $display("FAIL mc_done cyc%0d got=%b exp=%b", c, done, ed); end
      vectors++;
      if (stall !== es) begin errors++; $display("FAIL mc_raw_stall cyc%0d got=%b exp=%b", c, stall, es); end
      tick();
      mc_start = 1'b0;
    end
  endtask

  task automatic test_structural();
    clear_inputs();
    for (int c = 0; c <= MC_LAT + 1; c++) begin
      logic eb, ed, es;
      mc_start = (c == 0) || (c == 2);
      mc_rd    = (c == 2) ? 5'd5 : 5'd0;
      id_mc    = 1'b1;
      id_src   = {5'd0, 5'd5};
      id_vld   = (c == MC_LAT + 1) ? 2'b01 : 2'b00;
      eb = (c >= 1) && (c <= MC_LAT);
      ed = (c == MC_LAT);
      es = (c <= MC_LAT);
      @(negedge clk);
      vectors++;
      if (busy !== eb) begin errors++; $display("FAIL struct_busy cyc%0d got=%b exp=%b", c, busy, eb); end
      vectors++;
      if (done !== ed) begin errors++; $display("FAIL struct_done cyc%0d got=%b exp=%b", c, done, ed); end
      vectors++;
      if (stall !== es) begin errors++; $display("FAIL struct_stall cyc%0d got=%b exp=%b", c, stall, es); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_op();
    clear_inputs();
    mc_start = 1'b1; mc_rd = 5'd9; id_src = {5'd0, 5'd9}; id_vld = 2'b01;
    for (int c = 0; c <= 5; c++) begin
      rst_n = (c != 2);
      ie_src = {5'd0, 5'd3}; em_regwrite = (c == 2); em_rd = 5'd3;
      @(negedge clk);
      if (c == 2) begin
        vectors++;
        if ({fwd, stall, bubble} !== 6'b0) begin errors++; $display("FAIL rst_mid_forced got=%b exp=000000", {fwd, stall, bubble}); end
      end else if (c < 2) begin
        vectors++;
        if (stall !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_stall cyc%0d got=%b exp=1", c, stall); end
      end else begin
        vectors++;
        if ({busy, done, stall} !== 3'b000) begin errors++; $display("FAIL rst_mid_after cyc%0d got=%b exp=000", c, {busy, done, stall}); end
      end
      tick();
      mc_start = 1'b0;
    end
    rst_n = 1'b1;
    clear_inputs();
  endtask

`ifdef FWD_HAZARD_STATS_EN
  task automatic test_stats();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL stats_reset got=%0d exp=0", stall_cnt); end
    ie_memread = 1'b1; ie_rd = 5'd7; id_src = {5'd2, 5'd7}; id_vld = 2'b11;
    tick();
    clear_inputs();
    mc_start = 1'b1; mc_rd = 5'd9; id_src = {5'd0, 5'd9}; id_vld = 2'b01;
    tick();
    mc_start = 1'b0;
    for (int i = 0; i < MC_LAT; i++) tick();
    @(negedge clk);
    vectors++;
    if (stall_cnt !== 32'd5) begin errors++; $display("FAIL stats_count got=%0d exp=5", stall_cnt); end
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    m_scnt = 32'hFFFF_FFFE;
    clear_inputs();
    ie_memread = 1'b1; ie_rd = 5'd7; id_src = {5'd2, 5'd7}; id_vld = 2'b11;
    tick(); tick(); tick();
    @(negedge clk);
    vectors++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL stats_saturate got=%h exp=ffffffff", stall_cnt); end
    clear_inputs();
    tick();
  endtask
`endif

  task automatic test_random();
    clear_inputs();
    for (int i = 0; i < 400; i++) begin
      logic [2*NSRC-1:0] ef;
      bit es;
      rst_n = ($urandom_range(0, 39) != 0);
      for (int k = 0; k < NSRC; k++) begin
        ie_src[k*AW +: AW] = AW'($urandom_range(0, 7));
        id_src[k*AW +: AW] = AW'($urandom_range(0, 7));
      end
      id_vld      = NSRC'($urandom);
      em_regwrite = $urandom_range(0, 1) == 1;
      mw_regwrite = $urandom_range(0, 1) == 1;
      em_rd       = AW'($urandom_range(0, 7));
      mw_rd       = AW'($urandom_range(0, 7));
      ie_memread  = $urandom_range(0, 3) == 0;
      ie_rd       = AW'($urandom_range(0, 7));
      id_mc       = $urandom_range(0, 7) == 0;
      mc_start    = $urandom_range(0, 4) == 0;
      mc_rd       = AW'($urandom_range(0, 7));
      @(negedge clk);
      ef = m_fwd();
      es = m_stall();
      vectors++;
      if (fwd !== ef) begin errors++; $display("FAIL rand_fwd it%0d got=%b exp=%b", i, fwd, ef); end
      vectors++;
      if (stall !== es || bubble !== es) begin errors++; $display("FAIL rand_stall it%0d got=%b%b exp=%b", i, stall, bubble, es); end
      vectors++;
      if (busy !== m_busy() || done !== m_done()) begin
        errors++; $display("FAIL rand_mc it%0d got=%b%b exp=%b%b", i, busy, done, m_busy(), m_done());
      end
`ifdef FWD_HAZARD_STATS_EN
      vectors++;
      if (stall_cnt !== m_scnt) begin errors++; $display("FAIL rand_stats it%0d got=%0d exp=%0d", i, stall_cnt, m_scnt); end
`endif
      tick();
    end
    rst_n = 1'b1;
    clear_inputs();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "simulation timeout");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_multicycle();
    test_structural();
    test_reset_mid_op();
`ifdef FWD_HAZARD_STATS_EN
    test_stats();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
